bvh_node_fetch: RTL

- Pipelined BVH node fetch-and-decode unit. It sits between the traversal scheduler and the BVH node RAM.
- Accepts node-index requests, each carrying a per-instance offset. Issues in-order reads to node memory.
- Decodes each returned raw word into an offset-applied AABB plus N child references with leaf/null classification.
- Buffers decoded nodes in an output FIFO under credit-based flow control.
- Generalises the fixed 2-child, 32-bit combinational decoder to parametric width, fan-out and buffering depth.

---
 rtl/bvh_node_fetch.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bvh_node_fetch.sv
// BVH node fetch-and-decode unit.
// Accepts node-index requests, issues in-order reads to node RAM, decodes each
// returned raw word into an offset-applied AABB plus classified child refs,
// and buffers decoded nodes in a show-ahead FIFO under credit flow control.
//
// Handshake semantics (both req_* and node_*): a transfer happens on a rising
// clock edge where valid && ready are both high; valid never depends on ready,
// and a producer holds its payload stable while valid is high and ready low.
module bvh_node_fetch #(
  parameter int FIXED_W  = 32,
  parameter int INDEX_W  = 16,
  parameter int CHILDREN = 2,
  parameter int DEPTH    = 4,
  parameter int RAW_W    = 6*FIXED_W + CHILDREN*INDEX_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [INDEX_W-1:0]          req_index,
  input  logic [3*FIXED_W-1:0]        req_offset,
  output logic                        mem_rd_en,
  output logic [INDEX_W-1:0]          mem_rd_addr,
  input  logic                        mem_rd_valid,
  input  logic [RAW_W-1:0]            mem_rd_data,
  output logic                        node_valid,
  input  logic                        node_ready,
  output logic [3*FIXED_W-1:0]        node_min,
  output logic [3*FIXED_W-1:0]        node_max,
  output logic [CHILDREN*INDEX_W-1:0] node_child,
  output logic [CHILDREN-1:0]         node_leaf,
  output logic [CHILDREN-1:0]         node_null,
  output logic [INDEX_W-1:0]          node_index,
  output logic                        err_unexpected
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OFF_W = 3*FIXED_W;
  localparam int CH_W  = CHILDREN*INDEX_W;
  localparam logic [CNT_W:0] FULL_CNT = DEPTH[CNT_W:0];

  // Tag FIFO: request context waiting for its memory response.
  logic [INDEX_W-1:0] tag_index  [DEPTH];
  logic [OFF_W-1:0]   tag_offset [DEPTH];
  logic [PTR_W-1:0]   tag_wr_ptr, tag_rd_ptr;
  logic [CNT_W-1:0]   inflight;

  // Output FIFO: decoded nodes, head drives node_* directly.
  logic [OFF_W-1:0]    out_min   [DEPTH];
  logic [OFF_W-1:0]    out_max   [DEPTH];
  logic [CH_W-1:0]     out_child [DEPTH];
  logic [CHILDREN-1:0] out_leaf  [DEPTH];
  logic [CHILDREN-1:0] out_null  [DEPTH];
  logic [INDEX_W-1:0]  out_index [DEPTH];
  logic [PTR_W-1:0]    out_wr_ptr, out_rd_ptr;
  logic [CNT_W-1:0]    fifo_count;

  logic                accept, resp, pop;
  logic [CNT_W:0]      used;
  logic [OFF_W-1:0]    dec_min, dec_max;
  logic [CHILDREN-1:0] dec_leaf, dec_null;
  logic [OFF_W-1:0]    head_offset;

  // Credits: every slot is either in flight or buffered, so a response moving
  // a node from in-flight to buffered leaves the credit count unchanged.
  always_comb begin
    used        = {1'b0, inflight} + {1'b0, fifo_count};
    req_ready   = !reset && (used != FULL_CNT);
    accept      = req_valid && req_ready;
    resp        = mem_rd_valid && (inflight != '0);
    node_valid  = (fifo_count != '0);
    pop         = node_valid && node_ready;
    mem_rd_en   = accept;
    mem_rd_addr = accept ? req_index : '0;
    head_offset = tag_offset[tag_rd_ptr];
  end

  // Decode the returned word: fields are packed MSB first (min xyz, max xyz,
  // child0..childN-1). Leaf/null flags use the same child0-in-MSB ordering
  // as node_child so flag bit positions line up with the child fields.
  always_comb begin
    dec_min  = '0;
    dec_max  = '0;
    dec_leaf = '0;
    dec_null = '0;
    for (int d = 0; d < 3; d++) begin
      dec_min[OFF_W-1-d*FIXED_W -: FIXED_W] =
        mem_rd_data[RAW_W-1-d*FIXED_W -: FIXED_W] + head_offset[OFF_W-1-d*FIXED_W -: FIXED_W];
      dec_max[OFF_W-1-d*FIXED_W -: FIXED_W] =
        mem_rd_data[RAW_W-1-(d+3)*FIXED_W -: FIXED_W] + head_offset[OFF_W-1-d*FIXED_W -: FIXED_W];
    end
    for (int i = 0; i < CHILDREN; i++) begin
      dec_null[CHILDREN-1-i] = &mem_rd_data[CH_W-1-i*INDEX_W -: INDEX_W];
      dec_leaf[CHILDREN-1-i] = mem_rd_data[CH_W-1-i*INDEX_W] && !dec_null[CHILDREN-1-i];
    end
  end

  // Pointers, occupancy counters and the sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wr_ptr     <= '0;
      tag_rd_ptr     <= '0;
      inflight       <= '0;
      out_wr_ptr     <= '0;
      out_rd_ptr     <= '0;
      fifo_count     <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (accept) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (resp) begin
        tag_rd_ptr <= tag_rd_ptr + 1'b1;
        out_wr_ptr <= out_wr_ptr + 1'b1;
      end
      if (pop) out_rd_ptr <= out_rd_ptr + 1'b1;
      inflight   <= inflight + CNT_W'(accept) - CNT_W'(resp);
      fifo_count <= fifo_count + CNT_W'(resp) - CNT_W'(pop);
      if (mem_rd_valid && (inflight == '0)) err_unexpected <= 1'b1;
    end
  end

  // Tag storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_index[tag_wr_ptr]  <= req_index;
      tag_offset[tag_wr_ptr] <= req_offset;
    end
  end

  // Decoded-node storage, cleared on reset so outputs read zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        out_min[i]   <= '0;
        out_max[i]   <= '0;
        out_child[i] <= '0;
        out_leaf[i]  <= '0;
        out_null[i]  <= '0;
        out_index[i] <= '0;
      end
    end else if (resp) begin
      out_min[out_wr_ptr]   <= dec_min;
      out_max[out_wr_ptr]   <= dec_max;
      out_child[out_wr_ptr] <= mem_rd_data[CH_W-1:0];
      out_leaf[out_wr_ptr]  <= dec_leaf;
      out_null[out_wr_ptr]  <= dec_null;
      out_index[out_wr_ptr] <= tag_index[tag_rd_ptr];
    end
  end

  // Show-ahead head of the output FIFO.
  always_comb begin
    node_min   = out_min[out_rd_ptr];
    node_max   = out_max[out_rd_ptr];
    node_child = out_child[out_rd_ptr];
    node_leaf  = out_leaf[out_rd_ptr];
    node_null  = out_null[out_rd_ptr];
    node_index = out_index[out_rd_ptr];
  end

endmodule
